jacobi_stream_driver: RTL
=========================

# jacobi_stream_driver

Host-side driver for the Jacobi eigen-solver engine, sitting at the other end of the engine's input and output streams. It holds an N×N input matrix in a local buffer loaded by the host. On a start pulse it transmits the matrix in row-major order over a valid/ready stream into the engine, then collects the engine's result words into a result buffer that the host can read. It also reports busy/done status and a cycle count for the whole run.

## Interface
Parameters:
- N, 4, matrix dimension; N*N input words per run.
- IN_W, 32, width of an input word sent to the engine.
- OUT_W, 32, width of a result word received from the engine.
- OUT_COUNT, 4, number of result words expected per run (≥1).
- CNT_W, 32, width of the cycle counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_wr_en_i  in  1  matrix buffer write strobe.
- cfg_wr_addr_i  in  clog2(N*N)  row-major matrix word index.
- cfg_wr_dat_i  in  IN_W  matrix word.
- start_i  in  1  run request, sampled in IDLE only.
- busy_o  out  1  high from the cycle after start is accepted until done.
- done_o  out  1  one-cycle pulse at run completion.
- cycles_o  out  CNT_W  cycles spent in SEND+RECV in the last or current run.
- res_rd_addr_i  in  clog2(OUT_COUNT)  result index.
- res_rd_dat_o  out  OUT_W  result word, registered (1-cycle read latency).
- eng_dat_o  out  IN_W  stream word to the engine.
- eng_vld_o  out  1  stream valid to the engine.
- eng_rdy_i  in  1  engine ready.
- eng_dat_i  in  OUT_W  result word from the engine.
- eng_vld_i  in  1  result valid from the engine.
- eng_rdy_o  out  1  driver ready for a result.

## Operation
- States: IDLE, SEND, RECV, DONE.
- IDLE: busy_o=0. cfg writes land in the matrix buffer. start_i=1 -> SEND, clears tx_cnt, rx_cnt and cycles_o.
- SEND: words 0..N*N-1 are presented in order. A transfer occurs on eng_vld_o&&eng_rdy_i. After the last transfer: -> DONE if rx_cnt==OUT_COUNT, else -> RECV.
- RECV: eng_vld_o=0. Wait until rx_cnt reaches OUT_COUNT, then -> DONE.
- DONE: done_o=1 for exactly one cycle, then -> IDLE.
- Receive path is active in both SEND and RECV: eng_rdy_o = (state is SEND or RECV) && rx_cnt<OUT_COUNT. On eng_vld_i&&eng_rdy_o, the word is stored at index rx_cnt and rx_cnt increments. Results arriving early (during SEND) are kept.
- Any result beyond OUT_COUNT is not accepted (eng_rdy_o=0). eng_rdy_o is 0 in IDLE/DONE.
- cfg writes while busy_o=1 are ignored. start_i outside IDLE is ignored.
- cycles_o increments every cycle in SEND or RECV, saturating at all-ones. It holds its value after DONE until the next start.
- Matrix and result buffers are not cleared by reset or start.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; eng_vld_o=0, eng_dat_o=0, eng_rdy_o=0, busy_o=0, done_o=0, cycles_o=0, res_rd_dat_o=0; counters 0. Reset mid-run aborts immediately with no done_o pulse.
- start_i sampled high at edge t -> busy_o=1 and eng_vld_o=1 with word 0 from edge t+1.
- eng_dat_o is registered. While eng_vld_o && !eng_rdy_i, eng_dat_o and eng_vld_o hold stable.
- With eng_rdy_i held high, one word transfers per cycle: N*N transfers in N*N consecutive cycles, no bubbles.
- eng_vld_o deasserts the edge after the last transfer.
- done_o rises one cycle after the final required event (last tx or last rx, whichever is later). busy_o falls on the same edge as done_o falls.
- Boundary case: last tx and last rx complete in the same cycle -> SEND -> DONE directly.
- res_rd_dat_o = result[res_rd_addr_i] sampled at the previous edge. Reading during a run returns whatever is currently stored.

## Test plan
- Load matrix words k=0..15 with value 0x100+k; start; eng_rdy_i=1 constantly -> 16 consecutive transfers carrying 0x100..0x10F in order; eng_vld_o first high one cycle after start. Then feed 4 results 0xA0..0xA3 -> done_o pulses once, res_rd reads 0xA0..0xA3, cycles_o = 16 + receive cycles.
- Toggle eng_rdy_i pseudo-randomly during SEND -> no word dropped or duplicated; eng_dat_o stable while stalled.
- Present 2 results during SEND and 2 after -> all 4 stored in arrival order. Present all 4 before the last tx -> DONE directly after SEND, no RECV cycle.
- Present a 5th eng_vld_i word -> eng_rdy_o=0, result buffer unchanged.
- Pulse start_i and issue a cfg write mid-run -> both ignored; the following run re-sends the unchanged matrix.
- Assert rst low in the middle of SEND -> all outputs 0 asynchronously, no done_o; a subsequent start completes a normal run.

Source files
------------

// File: rtl/jacobi_stream_driver.sv
// Host-side driver for the Jacobi engine: streams a buffered N*N matrix out row-major,
// collects OUT_COUNT result words into a readable buffer, and reports busy/done/cycle count.
module jacobi_stream_driver #(
  parameter  int N         = 4,
  parameter  int IN_W      = 32,
  parameter  int OUT_W     = 32,
  parameter  int OUT_COUNT = 4,
  parameter  int CNT_W     = 32,
  localparam int NN        = N * N,
  localparam int AW        = (NN > 1) ? $clog2(NN) : 1,
  localparam int RW        = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1,
  localparam int CW        = $clog2(OUT_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr_en_i,
  input  logic [AW-1:0]    cfg_wr_addr_i,
  input  logic [IN_W-1:0]  cfg_wr_dat_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycles_o,
  input  logic [RW-1:0]    res_rd_addr_i,
  output logic [OUT_W-1:0] res_rd_dat_o,
  output logic [IN_W-1:0]  eng_dat_o,
  output logic             eng_vld_o,
  input  logic             eng_rdy_i,
  input  logic [OUT_W-1:0] eng_dat_i,
  input  logic             eng_vld_i,
  output logic             eng_rdy_o
);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              vld_q, vld_d;
  logic [IN_W-1:0]   dat_q, dat_d;
  logic [OUT_W-1:0]  res_rd_dat_q, res_rd_dat_d;

  logic [IN_W-1:0]   mat_mem [NN];
  logic [OUT_W-1:0]  res_mem [OUT_COUNT];

  logic tx_fire, rx_fire, running;

  assign running   = (state_q == SEND) || (state_q == RECV);
  assign eng_rdy_o = running && (rx_cnt_q < CW'(OUT_COUNT));
  assign tx_fire   = vld_q && eng_rdy_i;
  assign rx_fire   = eng_vld_i && eng_rdy_o;

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign cycles_o     = cycles_q;
  assign eng_vld_o    = vld_q;
  assign eng_dat_o    = dat_q;
  assign res_rd_dat_o = res_rd_dat_q;

  always_comb begin
    state_d      = state_q;
    tx_cnt_d     = tx_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    cycles_d     = cycles_q;
    vld_d        = vld_q;
    dat_d        = dat_q;
    res_rd_dat_d = res_mem[res_rd_addr_i];

    if (rx_fire) rx_cnt_d = rx_cnt_q + CW'(1);
    if (running && (cycles_q != '1)) cycles_d = cycles_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SEND;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          cycles_d = '0;
          vld_d    = 1'b1;
          dat_d    = mat_mem[0];
        end
      end
      SEND: begin
        if (tx_fire) begin
          if (tx_cnt_q == AW'(NN - 1)) begin
            vld_d = 1'b0;
            // Post-update rx count so a same-cycle final result skips RECV.
            state_d = (rx_cnt_d == CW'(OUT_COUNT)) ? DONE : RECV;
          end else begin
            tx_cnt_d = tx_cnt_q + AW'(1);
            dat_d    = mat_mem[tx_cnt_q + AW'(1)];
          end
        end
      end
      RECV: begin
        if (rx_cnt_d == CW'(OUT_COUNT)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      cycles_q     <= '0;
      vld_q        <= 1'b0;
      dat_q        <= '0;
      res_rd_dat_q <= '0;
    end else begin
      state_q      <= state_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      cycles_q     <= cycles_d;
      vld_q        <= vld_d;
      dat_q        <= dat_d;
      res_rd_dat_q <= res_rd_dat_d;
    end
  end

  // Buffers are plain storage: survive reset and start.
  always_ff @(posedge clk) begin
    if (cfg_wr_en_i && (state_q == IDLE)) mat_mem[cfg_wr_addr_i] <= cfg_wr_dat_i;
    if (rx_fire) res_mem[rx_cnt_q[RW-1:0]] <= eng_dat_i;
  end

endmodule
